gray_decoder: RTL and testbench

GRAY_DECODER -- requirements
Module: gray_decoder

---
 rtl/gray_pkg.sv | 13 +
 rtl/gray_to_bin.sv | 17 +
 rtl/gray_decoder.sv | 124 ++++++++++++
 tb/tb_gray_decoder.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared constants and FSM encoding for the Gray-code decoder slice.
package gray_pkg;

  localparam int GRAY_WIDTH_DEF = 3;
  localparam int WRAP_W_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_e;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary conversion: each binary bit is the XOR of all Gray bits at or above it.
// Latency 0; no flow control.
module gray_to_bin #(
  parameter int WIDTH = gray_pkg::GRAY_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/gray_decoder.sv
// Tracks an upstream Gray counter: decodes each accepted sample, flags direction, wraps and illegal jumps.
// Latency 1 cycle from the En sample edge; no backpressure, En=0 simply holds all state.
module gray_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH  = GRAY_WIDTH_DEF,
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  GrayIn,
  output logic [WIDTH-1:0]  Binary,
  output logic              Valid,
  output logic              Dir,
  output logic              Wrap,
  output logic              Overflow,
  output logic              Error,
  output logic [WRAP_W-1:0] WrapCount
);

  localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  binary_q, binary_d;
  logic              valid_q, valid_d;
  logic              dir_q, dir_d;
  logic              wrap_q, wrap_d;
  logic              overflow_q, overflow_d;
  logic              error_q, error_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

  logic [WIDTH-1:0]  sample_bin;
  logic [WIDTH-1:0]  delta;

  gray_to_bin #(.WIDTH(WIDTH)) u_gray_to_bin (
    .gray (GrayIn),
    .bin  (sample_bin)
  );

  assign delta = sample_bin - binary_q;

  always_comb begin
    state_d      = state_q;
    binary_d     = binary_q;
    valid_d      = valid_q;
    dir_d        = dir_q;
    wrap_d       = 1'b0;
    overflow_d   = overflow_q;
    error_d      = error_q;
    wrap_count_d = wrap_count_q;

    case (state_q)
      IDLE: begin
        // First sample seeds the tracker; there is no history to check it against.
        if (En) begin
          binary_d = sample_bin;
          valid_d  = 1'b1;
          dir_d    = 1'b1;
          state_d  = TRACK;
        end
      end
      TRACK: begin
        if (En) begin
          if (delta == STEP_UP) begin
            binary_d = sample_bin;
            dir_d    = 1'b1;
            if (binary_q == '1) begin
              wrap_d     = 1'b1;
              overflow_d = 1'b1;
              if (wrap_count_q != '1) begin
                wrap_count_d = wrap_count_q + WRAP_W'(1);
              end
            end
          end else if (delta == '1) begin
            binary_d = sample_bin;
            dir_d    = 1'b0;
          end else if (delta != '0) begin
            error_d = 1'b1;
            state_d = FAULT;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        error_d = 1'b1;
        state_d = FAULT;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= IDLE;
      binary_q     <= '0;
      valid_q      <= 1'b0;
      dir_q        <= 1'b1;
      wrap_q       <= 1'b0;
      overflow_q   <= 1'b0;
      error_q      <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      binary_q     <= binary_d;
      valid_q      <= valid_d;
      dir_q        <= dir_d;
      wrap_q       <= wrap_d;
      overflow_q   <= overflow_d;
      error_q      <= error_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign Binary    = binary_q;
  assign Valid     = valid_q;
  assign Dir       = dir_q;
  assign Wrap      = wrap_q;
  assign Overflow  = overflow_q;
  assign Error     = error_q;
  assign WrapCount = wrap_count_q;

endmodule

// File: tb/tb_gray_decoder.sv
// Directed bench for gray_decoder: WIDTH=3, WRAP_W=8, hand-computed expectations per scenario.
module tb_gray_decoder;
  import gray_pkg::*;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic [2:0] GrayIn;
  logic [2:0] Binary;
  logic       Valid;
  logic       Dir;
  logic       Wrap;
  logic       Overflow;
  logic       Error;
  logic [7:0] WrapCount;

  int total;
  int bad;

  // Gray codes for binary 0..7, in counting order.
  logic [2:0] gray_seq [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

  gray_decoder #(.WIDTH(3), .WRAP_W(8)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .En        (En),
    .GrayIn    (GrayIn),
    .Binary    (Binary),
    .Valid     (Valid),
    .Dir       (Dir),
    .Wrap      (Wrap),
    .Overflow  (Overflow),
    .Error     (Error),
    .WrapCount (WrapCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Applies inputs, lets one rising edge pass, returns 1 time unit after it.
  task automatic drive(input logic en, input logic [2:0] g);
    En     = en;
    GrayIn = g;
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    drive(1'b0, 3'b000);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 3'b000);
    total++; if (Binary !== 3'd0) begin bad++; $display("FAIL reset_binary got=%0d exp=0", Binary); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", Valid); end
    total++; if (Dir !== 1'b1) begin bad++; $display("FAIL reset_dir got=%0b exp=1", Dir); end
    total++; if (Wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap got=%0b exp=0", Wrap); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b exp=0", Overflow); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL reset_error got=%0b exp=0", Error); end
    total++; if (WrapCount !== 8'd0) begin bad++; $display("FAIL reset_wrapcount got=%0d exp=0", WrapCount); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
  endtask

  task automatic test_up_sequence();
    logic [2:0] g [9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    logic [2:0] b [9] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, g[i]);
      total++; if (Binary !== b[i]) begin bad++; $display("FAIL up_binary step=%0d got=%0d exp=%0d", i, Binary, b[i]); end
      total++; if (Wrap !== (i == 8)) begin bad++; $display("FAIL up_wrap step=%0d got=%0b exp=%0b", i, Wrap, (i == 8)); end
      total++; if (Dir !== 1'b1) begin bad++; $display("FAIL up_dir step=%0d got=%0b exp=1", i, Dir); end
      total++; if (Valid !== 1'b1) begin bad++; $display("FAIL up_valid step=%0d got=%0b exp=1", i, Valid); end
    end
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL up_overflow got=%0b exp=1", Overflow); end
    total++; if (WrapCount !== 8'd1) begin bad++; $display("FAIL up_wrapcount got=%0d exp=1", WrapCount); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL up_error got=%0b exp=0", Error); end
    drive(1'b0, 3'b000);
    total++; if (Wrap !== 1'b0) begin bad++; $display("FAIL up_wrap_one_cycle got=%0b exp=0", Wrap); end
    total++; if (WrapCount !== 8'd1) begin bad++; $display("FAIL up_wrapcount_hold got=%0d exp=1", WrapCount); end
  endtask

  task automatic test_illegal();
    do_reset();
    drive(1'b1, 3'b000);
    drive(1'b1, 3'b011);
    total++; if (Error !== 1'b1) begin bad++; $display("FAIL illegal_error got=%0b exp=1", Error); end
    total++; if (Binary !== 3'd0) begin bad++; $display("FAIL illegal_binary got=%0d exp=0", Binary); end
    total++; if (dut.state_q !== FAULT) begin bad++; $display("FAIL illegal_state got=%0d exp=%0d", dut.state_q, FAULT); end
    drive(1'b1, 3'b001);
    total++; if (Binary !== 3'd0) begin bad++; $display("FAIL fault_ignore_binary got=%0d exp=0", Binary); end
    total++; if (Error !== 1'b1) begin bad++; $display("FAIL fault_sticky_error got=%0b exp=1", Error); end
    total++; if (dut.state_q !== FAULT) begin bad++; $display("FAIL fault_stays got=%0d exp=%0d", dut.state_q, FAULT); end
    Reset = 1'b0;
    drive(1'b1, 3'b001);
    Reset = 1'b1;
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL fault_reset_error got=%0b exp=0", Error); end
    total++; if (dut.state_q !== IDLE) begin bad++; $display("FAIL fault_reset_state got=%0d exp=%0d", dut.state_q, IDLE); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL fault_reset_valid got=%0b exp=0", Valid); end
  endtask

  task automatic test_down_step();
    do_reset();
    drive(1'b1, 3'b000);
    drive(1'b1, 3'b100);
    total++; if (Binary !== 3'd7) begin bad++; $display("FAIL down_binary got=%0d exp=7", Binary); end
    total++; if (Dir !== 1'b0) begin bad++; $display("FAIL down_dir got=%0b exp=0", Dir); end
    total++; if (Wrap !== 1'b0) begin bad++; $display("FAIL down_wrap got=%0b exp=0", Wrap); end
    total++; if (Overflow !== 1'b0) begin bad++; $display("FAIL down_overflow got=%0b exp=0", Overflow); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL down_error got=%0b exp=0", Error); end
    drive(1'b1, 3'b100);
    total++; if (Binary !== 3'd7 || Dir !== 1'b0) begin bad++; $display("FAIL down_repeat got=%0d/%0b exp=7/0", Binary, Dir); end
    drive(1'b1, 3'b000);
    total++; if (Binary !== 3'd0 || Dir !== 1'b1 || Wrap !== 1'b1) begin bad++; $display("FAIL down_then_up got=%0d/%0b/%0b exp=0/1/1", Binary, Dir, Wrap); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 3'b000);
    drive(1'b1, 3'b001);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 3'b110);
      total++; if (Binary !== 3'd1) begin bad++; $display("FAIL hold_binary cyc=%0d got=%0d exp=1", i, Binary); end
      total++; if (Error !== 1'b0) begin bad++; $display("FAIL hold_error cyc=%0d got=%0b exp=0", i, Error); end
    end
    total++; if (Valid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%0b exp=1", Valid); end
  endtask

  task automatic test_reset_priority();
    do_reset();
    for (int i = 0; i < 6; i++) drive(1'b1, gray_seq[i]);
    total++; if (Binary !== 3'd5) begin bad++; $display("FAIL prio_setup_binary got=%0d exp=5", Binary); end
    Reset = 1'b0;
    drive(1'b1, 3'b101);
    Reset = 1'b1;
    total++; if (Binary !== 3'd0) begin bad++; $display("FAIL prio_binary got=%0d exp=0", Binary); end
    total++; if (Valid !== 1'b0) begin bad++; $display("FAIL prio_valid got=%0b exp=0", Valid); end
    total++; if (Dir !== 1'b1 || Wrap !== 1'b0 || Overflow !== 1'b0 || Error !== 1'b0 || WrapCount !== 8'd0) begin
      bad++; $display("FAIL prio_flags got=%0b%0b%0b%0b/%0d exp=1000/0", Dir, Wrap, Overflow, Error, WrapCount);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    drive(1'b1, 3'b000);
    for (int c = 1; c <= 300; c++) begin
      for (int s = 1; s <= 8; s++) drive(1'b1, gray_seq[s % 8]);
      if (c == 100) begin
        total++; if (WrapCount !== 8'd100) begin bad++; $display("FAIL sat_count100 got=%0d exp=100", WrapCount); end
      end
      if (c == 255) begin
        total++; if (WrapCount !== 8'd255) begin bad++; $display("FAIL sat_count255 got=%0d exp=255", WrapCount); end
      end
    end
    total++; if (WrapCount !== 8'd255) begin bad++; $display("FAIL sat_count300 got=%0d exp=255", WrapCount); end
    total++; if (Overflow !== 1'b1) begin bad++; $display("FAIL sat_overflow got=%0b exp=1", Overflow); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL sat_error got=%0b exp=0", Error); end
    total++; if (Wrap !== 1'b1) begin bad++; $display("FAIL sat_wrap_still_pulses got=%0b exp=1", Wrap); end
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    Reset  = 1'b0;
    En     = 1'b0;
    GrayIn = 3'b000;
    test_reset();
    test_up_sequence();
    test_illegal();
    test_down_step();
    test_hold();
    test_reset_priority();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
